// File: rtl/mtime_axil_bridge_pkg.sv
// -----------------------------------------------------------------------------
// mtime_axil_bridge_pkg
// Shared constants for the AXI4-Lite to mtime timer bridge:
//   - default MMIO word addresses of mtimecmp / mtime (low and high halves)
//   - AXI response codes
//   - bridge FSM state encoding
// -----------------------------------------------------------------------------
package mtime_axil_bridge_pkg;

    localparam logic [31:0] MTIMECMP_LO_ADDR = 32'h0200_4000;
    localparam logic [31:0] MTIMECMP_HI_ADDR = 32'h0200_4004;
    localparam logic [31:0] MTIME_LO_ADDR    = 32'h0200_BFF8;
    localparam logic [31:0] MTIME_HI_ADDR    = 32'h0200_BFFC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WCOLLECT = 3'd1;
    localparam state_t ST_WEXEC    = 3'd2;
    localparam state_t ST_WRESP    = 3'd3;
    localparam state_t ST_REXEC    = 3'd4;
    localparam state_t ST_RRESP    = 3'd5;

endpackage

// File: rtl/mtime_axil_bridge.sv
// -----------------------------------------------------------------------------
// mtime_axil_bridge
// AXI4-Lite slave in front of the mtime timer. Converts single AXI4-Lite
// transactions into the timer's flat addr / write-strobe / write-data
// interface, returns the timer's combinational read data on R, and registers
// the timer compare result into the machine timer interrupt (MTIP).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*        AXI4-Lite write address / data / response
//   s_ar*, s_r*              AXI4-Lite read address / data
//   mtime_addr_o             address to the timer (valid in WEXEC/REXEC)
//   mtime_write_valid_o      one-cycle write strobe to the timer
//   mtime_wdata_o            write data to the timer
//   mtime_rdata_i            combinational read data from the timer
//   mtime_ge_i               mtime >= mtimecmp from the timer
//   timer_irq_o              registered MTIP to the CSR unit
// -----------------------------------------------------------------------------
module mtime_axil_bridge
    import mtime_axil_bridge_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  MTIMECMP_LO = XLEN'(MTIMECMP_LO_ADDR),
    parameter logic [XLEN-1:0]  MTIMECMP_HI = XLEN'(MTIMECMP_HI_ADDR),
    parameter logic [XLEN-1:0]  MTIME_LO    = XLEN'(MTIME_LO_ADDR),
    parameter logic [XLEN-1:0]  MTIME_HI    = XLEN'(MTIME_HI_ADDR)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [XLEN-1:0] s_awaddr,
    input  logic            s_wvalid,
    output logic            s_wready,
    input  logic [XLEN-1:0] s_wdata,
    input  logic [3:0]      s_wstrb,
    output logic            s_bvalid,
    input  logic            s_bready,
    output logic [1:0]      s_bresp,

    input  logic            s_arvalid,
    output logic            s_arready,
    input  logic [XLEN-1:0] s_araddr,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [XLEN-1:0] s_rdata,
    output logic [1:0]      s_rresp,

    output logic [XLEN-1:0] mtime_addr_o,
    output logic            mtime_write_valid_o,
    output logic [XLEN-1:0] mtime_wdata_o,
    input  logic [XLEN-1:0] mtime_rdata_i,
    input  logic            mtime_ge_i,
    output logic            timer_irq_o
);

    state_t          state;
    logic            aw_got;
    logic            w_got;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      wstrb_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      bresp_q;
    logic [1:0]      rresp_q;
    logic            irq_q;

    logic            in_idle;
    logic            aw_hs;
    logic            w_hs;
    logic            ar_hs;
    logic            addr_ok;
    logic            write_ok;

    function automatic logic addr_mapped(input logic [XLEN-1:0] a);
        return (a == MTIMECMP_LO) || (a == MTIMECMP_HI) ||
               (a == MTIME_LO)    || (a == MTIME_HI);
    endfunction

    // Readies are decoded from the state; all of them are forced low while
    // reset is asserted. AR loses to any write activity seen in IDLE.
    always_comb begin
        in_idle   = (state == ST_IDLE);
        s_awready = !rst && (in_idle || ((state == ST_WCOLLECT) && !aw_got));
        s_wready  = !rst && (in_idle || ((state == ST_WCOLLECT) && !w_got));
        s_arready = !rst && in_idle && !s_awvalid && !s_wvalid;
        aw_hs     = s_awvalid && s_awready;
        w_hs      = s_wvalid && s_wready;
        ar_hs     = s_arvalid && s_arready;
        addr_ok   = addr_mapped(addr_q);
        write_ok  = addr_ok && (wstrb_q == 4'hF);
    end

    // A single address register serves both directions: only one transaction
    // is ever in flight, and the timer address simply holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs || w_hs) begin
                        if (aw_hs) addr_q <= s_awaddr;
                        if (w_hs) begin
                            wdata_q <= s_wdata;
                            wstrb_q <= s_wstrb;
                        end
                        aw_got <= aw_hs;
                        w_got  <= w_hs;
                        state  <= (aw_hs && w_hs) ? ST_WEXEC : ST_WCOLLECT;
                    end else if (ar_hs) begin
                        addr_q <= s_araddr;
                        state  <= ST_REXEC;
                    end
                end
                ST_WCOLLECT: begin
                    if (aw_hs) begin
                        addr_q <= s_awaddr;
                        aw_got <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= s_wdata;
                        wstrb_q <= s_wstrb;
                        w_got   <= 1'b1;
                    end
                    if (aw_hs || w_hs) state <= ST_WEXEC;
                end
                ST_WEXEC: begin
                    bresp_q <= write_ok ? RESP_OKAY : RESP_SLVERR;
                    state   <= ST_WRESP;
                end
                ST_WRESP: begin
                    if (s_bready) state <= ST_IDLE;
                end
                ST_REXEC: begin
                    rdata_q <= addr_ok ? mtime_rdata_i : '0;
                    rresp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
                    state   <= ST_RRESP;
                end
                ST_RRESP: begin
                    if (s_rready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MTIP follows the compare result with one cycle of latency, unrelated
    // to bus activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= mtime_ge_i;
    end

    always_comb begin
        s_bvalid            = (state == ST_WRESP);
        s_bresp             = bresp_q;
        s_rvalid            = (state == ST_RRESP);
        s_rdata             = rdata_q;
        s_rresp             = rresp_q;
        mtime_addr_o        = addr_q;
        mtime_wdata_o       = wdata_q;
        mtime_write_valid_o = (state == ST_WEXEC) && write_ok;
        timer_irq_o         = irq_q;
    end

endmodule

// File: tb/tb_mtime_axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_mtime_axil_bridge
// Self-checking bench for mtime_axil_bridge with a free-running timer model
// behind the bridge and a transaction-level reference for expected results.
// -----------------------------------------------------------------------------
module tb_mtime_axil_bridge;

    localparam logic [31:0] A_CMP_LO = 32'h0200_4000;
    localparam logic [31:0] A_CMP_HI = 32'h0200_4004;
    localparam logic [31:0] A_MT_LO  = 32'h0200_BFF8;
    localparam logic [31:0] A_MT_HI  = 32'h0200_BFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic [31:0] mtime_addr_o, mtime_wdata_o, mtime_rdata_i;
    logic        mtime_write_valid_o, mtime_ge_i, timer_irq_o;

    always #5 clk = ~clk;

    mtime_axil_bridge #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .mtime_addr_o(mtime_addr_o), .mtime_write_valid_o(mtime_write_valid_o),
        .mtime_wdata_o(mtime_wdata_o), .mtime_rdata_i(mtime_rdata_i),
        .mtime_ge_i(mtime_ge_i), .timer_irq_o(timer_irq_o)
    );

    // ---------------- timer model (free-running mtime, writable mtimecmp)
    logic [63:0] mtime, mtimecmp;
    logic        ge_ovr_en = 1'b0, ge_ovr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime    <= '0;
            mtimecmp <= '0;
        end else begin
            mtime <= mtime + 64'd1;
            if (mtime_write_valid_o) begin
                if (mtime_addr_o == A_CMP_LO) mtimecmp[31:0]  <= mtime_wdata_o;
                if (mtime_addr_o == A_CMP_HI) mtimecmp[63:32] <= mtime_wdata_o;
            end
        end
    end

    always_comb begin
        mtime_rdata_i = '0;
        case (mtime_addr_o)
            A_CMP_LO: mtime_rdata_i = mtimecmp[31:0];
            A_CMP_HI: mtime_rdata_i = mtimecmp[63:32];
            A_MT_LO:  mtime_rdata_i = mtime[31:0];
            A_MT_HI:  mtime_rdata_i = mtime[63:32];
            default:  mtime_rdata_i = '0;
        endcase
    end

    assign mtime_ge_i = ge_ovr_en ? ge_ovr : (mtime >= mtimecmp);

    // ---------------- cycle counter and write-pulse monitor
    int          cyc = 0;
    int          n_pulse = 0;
    int          pulse_cyc = -1;
    logic [31:0] pulse_addr, pulse_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mtime_write_valid_o === 1'b1) begin
            n_pulse++;
            pulse_cyc  = cyc;
            pulse_addr = mtime_addr_o;
            pulse_data = mtime_wdata_o;
        end
    end

    // ---------------- reference: expected register contents and decode rules
    logic [31:0] ref_cmp_lo = '0, ref_cmp_hi = '0;

    function automatic bit is_mapped(input logic [31:0] a);
        return (a == A_CMP_LO) || (a == A_CMP_HI) || (a == A_MT_LO) || (a == A_MT_HI);
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly,
                             input int w_dly, input int b_dly);
        int   p0, last_hs, bv_first, bv_cnt;
        bit   aw_done, w_done, b_done, b_stable, ok;
        logic [1:0] b_first_resp;
        p0 = n_pulse; last_hs = -1; bv_first = -1; bv_cnt = 0;
        aw_done = 0; w_done = 0; b_done = 0; b_stable = 1; b_first_resp = '0;
        for (int t = 0; t < 100 && !b_done; t++) begin
            @(negedge clk);
            s_awvalid = !aw_done && (t >= aw_dly);
            s_awaddr  = addr;
            s_wvalid  = !w_done && (t >= w_dly);
            s_wdata   = data;
            s_wstrb   = strb;
            s_bready  = (bv_cnt >= b_dly);
            #1;
            if (s_bvalid) begin
                if (bv_first < 0) begin
                    bv_first     = cyc;
                    b_first_resp = s_bresp;
                end else if (s_bresp !== b_first_resp) begin
                    b_stable = 0;
                end
                bv_cnt++;
            end
            if (s_awvalid && s_awready) begin aw_done = 1; last_hs = cyc; end
            if (s_wvalid && s_wready)   begin w_done = 1;  last_hs = cyc; end
            if (s_bvalid && s_bready) b_done = 1;
        end
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0; s_bready = 0;
        ok = is_mapped(addr) && (strb == 4'hF);
        check_eq("wr_done", b_done, 1);
        check_eq("wr_npulse", n_pulse - p0, ok ? 1 : 0);
        if (ok) begin
            check_eq("wr_pulse_cyc", pulse_cyc, last_hs + 1);
            check_eq("wr_pulse_addr", pulse_addr, addr);
            check_eq("wr_pulse_data", pulse_data, data);
            if (addr == A_CMP_LO) ref_cmp_lo = data;
            if (addr == A_CMP_HI) ref_cmp_hi = data;
        end
        check_eq("wr_bvalid_cyc", bv_first, last_hs + 2);
        check_eq("wr_bresp", b_first_resp, ok ? 2'b00 : 2'b10);
        check_eq("wr_b_stable", b_stable, 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly);
        int          hs, rv_first, rv_cnt;
        bit          r_done, r_stable;
        logic [63:0] snap;
        logic [31:0] r_first_data, exp;
        logic [1:0]  r_first_resp;
        hs = -1; rv_first = -1; rv_cnt = 0; r_done = 0; r_stable = 1;
        snap = '0; r_first_data = '0; r_first_resp = '0;
        for (int t = 0; t < 100 && !r_done; t++) begin
            @(negedge clk);
            s_arvalid = (hs < 0);
            s_araddr  = addr;
            s_rready  = (rv_cnt >= r_dly);
            #1;
            if (s_rvalid) begin
                if (rv_first < 0) begin
                    rv_first     = cyc;
                    r_first_data = s_rdata;
                    r_first_resp = s_rresp;
                end else if (s_rdata !== r_first_data || s_rresp !== r_first_resp) begin
                    r_stable = 0;
                end
                rv_cnt++;
            end
            // the counter is read one cycle after the AR handshake
            if (s_arvalid && s_arready) begin hs = cyc; snap = mtime + 64'd1; end
            if (s_rvalid && s_rready) r_done = 1;
        end
        @(negedge clk);
        s_arvalid = 0; s_rready = 0;
        case (addr)
            A_CMP_LO: exp = ref_cmp_lo;
            A_CMP_HI: exp = ref_cmp_hi;
            A_MT_LO:  exp = snap[31:0];
            A_MT_HI:  exp = snap[63:32];
            default:  exp = '0;
        endcase
        check_eq("rd_done", r_done, 1);
        check_eq("rd_rvalid_cyc", rv_first, hs + 2);
        check_eq("rd_rdata", r_first_data, exp);
        check_eq("rd_rresp", r_first_resp, is_mapped(addr) ? 2'b00 : 2'b10);
        check_eq("rd_r_stable", r_stable, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] wr_addrs [5] = '{A_CMP_LO, A_CMP_HI, 32'h0200_0000, 32'h0200_4001, 32'h0200_BFF9};
    logic [31:0] rd_addrs [7] = '{A_CMP_LO, A_CMP_HI, A_MT_LO, A_MT_HI,
                                  32'h0200_0008, 32'h0200_4002, 32'h0200_C000};

    initial begin
        int p0;
        rst = 1'b1;
        s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
        s_bready = 0; s_arvalid = 0; s_araddr = '0; s_rready = 0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_awready", s_awready, 0);
        check_eq("rst_wready", s_wready, 0);
        check_eq("rst_arready", s_arready, 0);
        check_eq("rst_valids", {s_bvalid, s_rvalid, mtime_write_valid_o}, 0);
        check_eq("rst_resps", {s_bresp, s_rresp}, 0);
        check_eq("rst_rdata", s_rdata, 0);
        check_eq("rst_addr_wdata", {mtime_addr_o, mtime_wdata_o}, 0);
        check_eq("rst_irq", timer_irq_o, 0);

        @(negedge clk); rst = 1'b0;
        #1 check_eq("irq_before_edge", timer_irq_o, 0);
        @(negedge clk); #1 check_eq("irq_after_release", timer_irq_o, 1);

        // directed cases
        axi_read(A_MT_LO, 3);
        axi_write(A_CMP_LO, 32'h0000_0010, 4'hF, 0, 0, 0);
        axi_write(A_CMP_HI, 32'h0000_0000, 4'hF, 3, 0, 4);
        axi_write(32'h0200_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
        axi_write(A_CMP_LO, 32'h1234_5678, 4'h3, 1, 0, 0);
        axi_read(32'h0200_0008, 2);
        axi_read(A_CMP_LO, 0);
        axi_write(A_CMP_LO, 32'hCAFE_0001, 4'hF, 0, 2, 2);
        axi_read(A_MT_HI, 1);

        // AW, W and AR together: write first, then the read; reset in RRESP
        @(negedge clk);
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 0;
        s_awaddr = A_CMP_HI; s_wdata = 32'h0000_00A5; s_wstrb = 4'hF; s_araddr = A_CMP_HI;
        #1;
        check_eq("race_arready_low", s_arready, 0);
        check_eq("race_aw_w_ready", {s_awready, s_wready}, 2'b11);
        @(negedge clk); s_awvalid = 0; s_wvalid = 0;
        #1;
        check_eq("race_wexec_pulse", mtime_write_valid_o, 1);
        check_eq("race_wexec_arready", s_arready, 0);
        @(negedge clk); #1;
        check_eq("race_bvalid", {s_bvalid, s_bresp}, 3'b100);
        ref_cmp_hi = 32'h0000_00A5;
        @(negedge clk); #1;
        check_eq("race_ar_accept", s_arready, 1);
        @(negedge clk); s_arvalid = 0; s_bready = 0;
        #1 check_eq("race_rexec_rvalid", s_rvalid, 0);
        @(negedge clk); #1;
        check_eq("race_rvalid", s_rvalid, 1);
        check_eq("race_rdata", s_rdata, ref_cmp_hi);
        p0 = n_pulse;
        rst = 1'b1;
        #1;
        check_eq("rst_rrésp_rvalid_drop", s_rvalid, 0);
        check_eq("rst_mid_arready", s_arready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_cmp_lo = '0; ref_cmp_hi = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_no_pulse", n_pulse - p0, 0);
        check_eq("rst_state_idle", s_arready, 1);

        // interrupt follows mtime_ge_i with one cycle of latency
        ge_ovr_en = 1; ge_ovr = 0;
        @(negedge clk); #1 check_eq("irq_low", timer_irq_o, 0);
        ge_ovr = 1;
        #1 check_eq("irq_not_yet", timer_irq_o, 0);
        @(negedge clk); #1 check_eq("irq_high", timer_irq_o, 1);
        ge_ovr = 0;
        @(negedge clk); #1 check_eq("irq_fall", timer_irq_o, 0);
        ge_ovr_en = 0;

        // randomized mix against the reference
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [3:0] strb;
                strb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                axi_write(wr_addrs[$urandom_range(0, 4)], $urandom, strb,
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                axi_read(rd_addrs[$urandom_range(0, 6)], $urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mtime_axil_bridge.md
Name: mtime_axil_bridge

Overview:
AXI4-Lite slave that sits directly upstream of the mtime timer block. It converts AXI4-Lite read/write transactions from the core's MMIO interconnect into the timer's flat address / write-valid / write-data interface and returns the timer's combinational read data as an R-channel response. It also registers the timer's compare output into the machine timer-interrupt line that goes to the CSR unit (mip.MTIP).

Parameters:
- XLEN, 32, data and address width.
- MTIMECMP_LO, 32'h0200_4000, mtimecmp low word address.
- MTIMECMP_HI, 32'h0200_4004, mtimecmp high word address.
- MTIME_LO, 32'h0200_BFF8, mtime low word address.
- MTIME_HI, 32'h0200_BFFC, mtime high word address.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  XLEN  write address
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  XLEN  write data
- s_wstrb  in  4  byte strobes
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  OKAY=2'b00, SLVERR=2'b10
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  XLEN  read address
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  XLEN  read data
- s_rresp  out  2  read response
- mtime_addr_o  out  XLEN  address to the timer
- mtime_write_valid_o  out  1  single-cycle write strobe to the timer
- mtime_wdata_o  out  XLEN  write data to the timer
- mtime_rdata_i  in  XLEN  combinational read data from the timer
- mtime_ge_i  in  1  mtime >= mtimecmp from the timer
- timer_irq_o  out  1  registered MTIP to the CSR unit

Behaviour:
- Reset values: all ready and valid outputs 0; bresp, rresp, rdata, wdata, addr 0; mtime_write_valid_o 0; timer_irq_o 0.
- Reset asserted mid-transaction: the in-flight transaction is abandoned, the FSM returns to IDLE, and no write pulse is issued.
- FSM states: IDLE, WCOLLECT, WEXEC, WRESP, REXEC, RRESP.
- IDLE:
  - awready, wready and arready are all 1.
  - If any write channel (AW or W) handshakes, the write path is taken and read has lower priority. arready drops combinationally in that case, so AR is not accepted in the same cycle.
  - If AW and W both handshake: go to WEXEC. If only one handshakes: capture it and go to WCOLLECT.
  - If AR handshakes with no write activity: capture araddr and go to REXEC.
- WCOLLECT: the ready of the already-captured channel is 0. Wait for the other channel, capture it, then go to WEXEC.
- WEXEC, exactly one cycle:
  - Drive mtime_addr_o = captured awaddr and mtime_wdata_o = captured wdata.
  - mtime_write_valid_o = 1 only if the address is one of the 4 mapped words AND wstrb == 4'hF. In that case bresp = OKAY.
  - Otherwise there is no write pulse and bresp = SLVERR.
  - Next state: WRESP.
- WRESP: bvalid = 1 and bresp is held stable until bready. On bvalid & bready, go to IDLE.
- REXEC, exactly one cycle:
  - Drive mtime_addr_o = captured araddr.
  - Register rdata = mtime_rdata_i and rresp = OKAY if the address is mapped. Otherwise rdata = 0 and rresp = SLVERR.
  - Next state: RRESP.
- RRESP: rvalid = 1 and rdata/rresp are held stable until rready, then go to IDLE.
- Latency:
  - AR handshake in cycle N gives rvalid in N+2.
  - A write whose last address/data handshake is in cycle N pulses mtime_write_valid_o in N+1 and asserts bvalid in N+2.
- mtime_addr_o holds its last value outside WEXEC/REXEC. It is only meaningful when qualified by the write strobe or the REXEC state.
- Only one outstanding transaction at a time; no overlap between read and write.
- A read of mtime low returns the counter value sampled in the REXEC cycle.
- Addresses are compared as full 32-bit values; unaligned or unmapped addresses get SLVERR.
- timer_irq_o is updated every cycle from the previous cycle's mtime_ge_i (1-cycle latency) and is independent of the FSM. After reset, mtimecmp = 0, so timer_irq_o rises 1 cycle after rst deasserts.

Decomposition:
- Shared package/header: the four address constants, the AXI response codes (OKAY, SLVERR), and the FSM state encoding.
- No sub-module; the address-decode function stays inline.

Test Plan:
- Write 32'h0000_0010 to MTIMECMP_LO with AW and W in the same cycle, strobe F -> one-cycle mtime_write_valid_o with addr 0x0200_4000 and wdata 0x10; bvalid two cycles later with bresp 00.
- W arrives 3 cycles before AW, and bready is held low 4 cycles -> exactly one write pulse, in the cycle after AW; bvalid and bresp stay stable until bready.
- Read MTIME_LO after reset, with the timer model free-running -> rvalid at N+2; rdata equals the counter value in cycle N+1; rresp 00; rdata held while rready is low.
- Write to 0x0200_0000 and a write with wstrb 4'h3 -> no write pulse, bresp 10. Read from 0x0200_0008 -> rdata 0, rresp 10.
- AW, W and AR asserted in the same cycle -> write completes first, AR is then accepted from IDLE; assert rst during RRESP -> rvalid drops immediately and no stray write pulse occurs.
- Drive mtime_ge_i 0→1→0 -> timer_irq_o follows one cycle later; it is 1 after reset release with mtimecmp = 0.
